// File: rtl/serial_byte_deframer_if.sv
// serial_byte_deframer_if: serial input and deframed byte/strobe outputs of the byte deframer
interface serial_byte_deframer_if;
    logic       serial_data;
    logic       data_ena;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       header_found;
    logic       packet_type;
    logic       packet_done;
    logic       frame_err;
    logic       busy;
    modport master (
        output serial_data, data_ena,
        input  byte_out, byte_valid, header_found, packet_type, packet_done, frame_err, busy
    );
    modport slave (
        input  serial_data, data_ena,
        output byte_out, byte_valid, header_found, packet_type, packet_done, frame_err, busy
    );
endinterface

// File: rtl/serial_byte_deframer.sv
// serial_byte_deframer: MSB-first serial byte capture, header hunt and payload byte delivery
module serial_byte_deframer #(
    parameter logic [7:0] HEADER_A      = 8'hA5,
    parameter logic [7:0] HEADER_B      = 8'hC3,
    parameter int         PAYLOAD_BYTES = 4
) (
    input  logic                  clk_50,
    input  logic                  reset_n,
    serial_byte_deframer_if.slave bus
);
    typedef enum logic {HUNT, PAYLOAD} state_t;
    state_t     state, state_n;
    logic [7:0] shift, byte_q, byte_n;
    logic [3:0] bit_cnt, byte_cnt, byte_cnt_n;
    logic       ena_d, type_q, type_n;
    logic       hdr_q, hdr_n, valid_q, valid_n, done_q, done_n, err_q, err_n;
    logic       byte_end, good, is_a, is_b, last;

    assign byte_end = !bus.data_ena && ena_d;
    assign good     = bit_cnt == 4'd8;
    assign is_a     = shift == HEADER_A;
    assign is_b     = shift == HEADER_B;
    assign last     = byte_cnt == 4'(PAYLOAD_BYTES - 1);

    always_ff @(posedge clk_50 or negedge reset_n)
        if (!reset_n) state <= HUNT;
        else          state <= state_n;

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        byte_n     = byte_q;
        type_n     = type_q;
        hdr_n      = 1'b0;
        valid_n    = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        if (byte_end) begin
            if (!good) begin
                err_n      = 1'b1;
                state_n    = HUNT;
                byte_cnt_n = 4'd0;
            end else if (state == HUNT) begin
                if (is_a || is_b) begin
                    hdr_n      = 1'b1;
                    type_n     = is_b;
                    byte_cnt_n = 4'd0;
                    state_n    = PAYLOAD;
                end
            end else begin
                // in PAYLOAD every good byte is data, header values included
                byte_n     = shift;
                valid_n    = 1'b1;
                done_n     = last;
                byte_cnt_n = last ? 4'd0 : byte_cnt + 4'd1;
                state_n    = last ? HUNT : PAYLOAD;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n)
        if (!reset_n) begin
            shift    <= 8'd0;
            bit_cnt  <= 4'd0;
            byte_cnt <= 4'd0;
            ena_d    <= 1'b0;
            byte_q   <= 8'd0;
            type_q   <= 1'b0;
            hdr_q    <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ena_d    <= bus.data_ena;
            byte_cnt <= byte_cnt_n;
            byte_q   <= byte_n;
            type_q   <= type_n;
            hdr_q    <= hdr_n;
            valid_q  <= valid_n;
            done_q   <= done_n;
            err_q    <= err_n;
            if (bus.data_ena) begin
                shift   <= {shift[6:0], bus.serial_data};
                bit_cnt <= (bit_cnt == 4'd9) ? 4'd9 : bit_cnt + 4'd1;
            end else if (byte_end) begin
                bit_cnt <= 4'd0;
            end
        end

    assign bus.byte_out     = byte_q;
    assign bus.byte_valid   = valid_q;
    assign bus.header_found = hdr_q;
    assign bus.packet_type  = type_q;
    assign bus.packet_done  = done_q;
    assign bus.frame_err    = err_q;
    assign bus.busy         = state == PAYLOAD;
endmodule

// File: tb/tb_serial_byte_deframer.sv
// tb_serial_byte_deframer: directed serial bytes with a strobe scoreboard checked by a monitor
module tb_serial_byte_deframer;
    logic clk_50 = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   last_fall = 0;

    typedef struct packed {
        int         cyc;
        logic       hf, bv, pd, fe;
        logic [7:0] bo;
        logic       pt, busy;
    } ev_t;
    ev_t q[$];

    serial_byte_deframer_if bus();
    serial_byte_deframer dut (.clk_50(clk_50), .reset_n(reset_n), .bus(bus.slave));

    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(posedge clk_50); #1;
            bus.data_ena    = 1'b1;
            bus.serial_data = v[i];
        end
        @(posedge clk_50); #1;
        bus.data_ena    = 1'b0;
        bus.serial_data = 1'b0;
        last_fall       = cyc;
    endtask

    task automatic exp(input logic hf, bv, pd, fe, input logic [7:0] bo, input logic pt, busy);
        q.push_back('{cyc: last_fall + 1, hf: hf, bv: bv, pd: pd, fe: fe, bo: bo, pt: pt, busy: busy});
    endtask

    task automatic hdr(input logic [7:0] b, input logic [7:0] bo, input logic pt);
        send_bits({8'd0, b}, 8);
        exp(1, 0, 0, 0, bo, pt, 1);
    endtask

    task automatic pay(input logic [7:0] b, input logic pt, input logic lst);
        send_bits({8'd0, b}, 8);
        exp(0, 1, lst, 0, b, pt, !lst);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({bus.header_found, bus.byte_valid, bus.packet_done, bus.frame_err,
             bus.byte_out, bus.packet_type, bus.busy} !== 14'd0) begin
            fails++;
            $display("FAIL %s: hf=%b bv=%b pd=%b fe=%b bo=%h pt=%b busy=%b, required all zero",
                     name, bus.header_found, bus.byte_valid, bus.packet_done, bus.frame_err,
                     bus.byte_out, bus.packet_type, bus.busy);
        end
    endtask

    initial forever begin
        @(negedge clk_50);
        if (reset_n && (bus.header_found || bus.byte_valid || bus.packet_done || bus.frame_err)) begin
            ev_t a, e;
            a = '{cyc: cyc, hf: bus.header_found, bv: bus.byte_valid, pd: bus.packet_done,
                  fe: bus.frame_err, bo: bus.byte_out, pt: bus.packet_type, busy: bus.busy};
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: cyc=%0d hf=%b bv=%b pd=%b fe=%b bo=%h, required no strobe",
                         a.cyc, a.hf, a.bv, a.pd, a.fe, a.bo);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    fails++;
                    $display("FAIL strobe_event: got cyc=%0d hf=%b bv=%b pd=%b fe=%b bo=%h pt=%b busy=%b, required cyc=%0d hf=%b bv=%b pd=%b fe=%b bo=%h pt=%b busy=%b",
                             a.cyc, a.hf, a.bv, a.pd, a.fe, a.bo, a.pt, a.busy,
                             e.cyc, e.hf, e.bv, e.pd, e.fe, e.bo, e.pt, e.busy);
                end
            end
        end
    end

    initial begin
        bus.data_ena    = 1'b0;
        bus.serial_data = 1'b0;
        repeat (3) @(posedge clk_50);
        #1;
        check_zero("reset_state");
        reset_n = 1'b1;
        // packet A with payload 11..44; data_ena rises on the first cycle out of reset
        hdr(8'hA5, 8'h00, 0);
        pay(8'h11, 0, 0);
        pay(8'h22, 0, 0);
        pay(8'h33, 0, 0);
        pay(8'h44, 0, 1);
        // junk byte ignored, packet B whose payload contains header values
        send_bits(16'h0000, 8);
        hdr(8'hC3, 8'h44, 1);
        pay(8'hA5, 1, 0);
        pay(8'hC3, 1, 0);
        pay(8'h01, 1, 0);
        pay(8'h02, 1, 1);
        // short byte aborts a packet, then a fresh packet
        hdr(8'hA5, 8'h02, 0);
        pay(8'h11, 0, 0);
        send_bits(16'h003F, 6);
        exp(0, 0, 0, 1, 8'h11, 0, 0);
        hdr(8'hA5, 8'h11, 0);
        pay(8'h01, 0, 0);
        pay(8'h02, 0, 0);
        pay(8'h03, 0, 0);
        pay(8'h04, 0, 1);
        // 9-bit byte whose last 8 bits are A5
        send_bits(16'h01A5, 9);
        exp(0, 0, 0, 1, 8'h04, 0, 0);
        // reset pulse mid-packet
        hdr(8'hA5, 8'h04, 0);
        pay(8'hAA, 0, 0);
        pay(8'hBB, 0, 0);
        repeat (2) @(posedge clk_50);
        #1;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset_mid_packet");
        @(posedge clk_50); #1;
        reset_n = 1'b1;
        hdr(8'hA5, 8'h00, 0);
        pay(8'hAA, 0, 0);
        pay(8'hBB, 0, 0);
        pay(8'hCC, 0, 0);
        pay(8'hDD, 0, 1);
        // idle time: no strobes may appear and all expectations must be consumed
        repeat (20) @(posedge clk_50);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_strobes: %0d expected events pending, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_byte_deframer.md
Name: serial_byte_deframer

Overview:
Upstream stage of the 50 MHz FIFO write controller. Deserialises the MSB-first serial stream gated by data_ena and hunts for a packet header byte (0xA5 or 0xC3). It then delivers the payload bytes as a parallel byte with a one-cycle valid strobe for the FIFO write path. It also flags malformed bytes and provides the header_found pulse the write controller consumes.

Parameters:
HEADER_A, 8'hA5, first accepted header value (packet_type 0)
HEADER_B, 8'hC3, second accepted header value (packet_type 1)
PAYLOAD_BYTES, 4, payload bytes per packet after the header; legal range 1..15

Ports:
clk_50  input  1  50 MHz clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
serial_data  input  1  serial bit, sampled every clk_50 while data_ena=1, MSB first
data_ena  input  1  high for exactly 8 cycles per byte, low for at least 1 cycle between bytes
byte_out  output  8  last completed payload byte, held until next payload byte
byte_valid  output  1  one-cycle strobe, byte_out is a new payload byte
header_found  output  1  one-cycle strobe, a header byte was accepted
packet_type  output  1  0 = HEADER_A, 1 = HEADER_B; latched at header accept
packet_done  output  1  one-cycle strobe coincident with byte_valid of last payload byte
frame_err  output  1  one-cycle strobe, byte with bit count ≠ 8 discarded
busy  output  1  1 while in PAYLOAD state

Behaviour:
- Reset (async, reset_n=0): state=HUNT, shift register=0, bit_cnt=0, byte_cnt=0, ena_d=0. All outputs 0, including byte_out and packet_type.
- Sampling: each cycle with data_ena=1: shift <= {shift[6:0], serial_data}; bit_cnt increments, saturating at 9.
- Byte end event: data_ena=0 AND ena_d=1, where ena_d is data_ena registered one cycle. Evaluated on that edge. Bit_cnt is cleared on that edge.
- Outputs are registered. Strobes are high exactly the one cycle following the byte-end edge, giving a latency of 1 cycle after data_ena falls.
- bit_cnt≠8 at byte end: frame_err=1, byte discarded, state forced to HUNT, byte_cnt=0. No byte_valid, no packet_done.
- State HUNT, good byte:
  - Byte equals HEADER_A or HEADER_B: header_found=1, packet_type set (0 for A, 1 for B), byte_cnt=0, go to PAYLOAD.
  - Any other byte: ignored silently, no strobe.
- State PAYLOAD, good byte:
  - byte_out<=byte, byte_valid=1, byte_cnt++.
  - A header value here is data, not a header.
  - When byte_cnt reaches PAYLOAD_BYTES: packet_done=1 with that byte_valid, byte_cnt=0, return to HUNT.
- busy=1 in PAYLOAD, 0 in HUNT; updates the same edge as the state.
- data_ena held low: no activity, state retained indefinitely (no timeout).
- data_ena high >8 cycles: bit_cnt saturates at 9, giving frame_err at the eventual byte end.
- data_ena=1 at the first cycle after reset: counted normally. ena_d=0 after reset, so no spurious byte end.
- Reset mid-packet: immediate return to HUNT, partial byte and count lost, no strobes.
- Strobes are mutually exclusive except packet_done with byte_valid.

Test Plan:
1. Reset, then bytes A5,11,22,33,44 -> header_found at byte 1 with packet_type=0; byte_valid ×4 with byte_out 11,22,33,44; packet_done with 44; busy 1 from header to after 44.
2. Bytes 00,C3,A5,C3,01,02 -> 00 ignored; header_found with packet_type=1; payload A5,C3,01,02 all byte_valid (headers as data); packet_done with 02.
3. Header A5, payload 11, then a 6-bit byte -> frame_err 1 cycle, busy drops, no byte_valid. Next A5,01..04 is accepted as a fresh packet.
4. data_ena high 9 cycles in HUNT -> frame_err, no header_found even if the last 8 bits are A5.
5. reset_n pulsed low for 1 cycle after 2 payload bytes -> all outputs 0 immediately. A5,AA,BB,CC,DD afterwards gives a full packet with byte_out DD on packet_done.
6. Byte-end timing: data_ena falls at cycle N -> strobe observed high only in cycle N+1; back-to-back bytes with 1-cycle gaps produce no missed strobes.
